// File: rtl/packet_framer_if.sv
// packet_framer_if: raw sample sink plus Avalon-ST packet source bundle.
// master = framer side, slave = producer/consumer side.
interface packet_framer_if;
  logic [31:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic [31:0] data_out_data;
  logic        data_out_valid;
  logic        data_out_ready;
  logic        data_out_startofpacket;
  logic        data_out_endofpacket;
  logic [1:0]  data_out_empty;

  modport master (
    input  sample_data,
    input  sample_valid,
    output sample_ready,
    output data_out_data,
    output data_out_valid,
    input  data_out_ready,
    output data_out_startofpacket,
    output data_out_endofpacket,
    output data_out_empty
  );

  modport slave (
    output sample_data,
    output sample_valid,
    input  sample_ready,
    input  data_out_data,
    input  data_out_valid,
    output data_out_ready,
    input  data_out_startofpacket,
    input  data_out_endofpacket,
    input  data_out_empty
  );
endinterface

// File: rtl/packet_framer.sv
// packet_framer: frames a raw 32-bit sample stream into sync/frame/ts + payload packets.
// Define FRAMER_CHECKSUM_EN to append an XOR checksum trailer word.
module packet_framer #(
  parameter int unsigned PAYLOAD_WORDS = 160,
  parameter logic [31:0] SYNC_WORD     = 32'hA5A5_0001
) (
  input  logic            clk_clk,
  input  logic            rst_reset,
  input  logic            enable,
  packet_framer_if.master st,
  output logic [31:0]     frame_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR0 = 3'd1;
  localparam logic [2:0] S_HDR1 = 3'd2;
  localparam logic [2:0] S_HDR2 = 3'd3;
  localparam logic [2:0] S_PAY  = 3'd4;
`ifdef FRAMER_CHECKSUM_EN
  localparam logic [2:0] S_TRL  = 3'd5;
`endif

  localparam logic [15:0] LAST_IDX = 16'(PAYLOAD_WORDS - 1);

  logic [2:0]  state_q, state_d;
  logic [31:0] frame_q, frame_d;
  logic [31:0] ts_q;
  logic [31:0] tslat_q, tslat_d;
  logic [15:0] word_q, word_d;
`ifdef FRAMER_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;
`endif

  logic        vld;
  logic        srdy;
  logic        sop;
  logic        eop;
  logic [31:0] dat;
  logic        beat;
  logic        pay_last;

  assign beat     = vld & st.data_out_ready;
  assign pay_last = (word_q == LAST_IDX);

  always_comb begin
    vld  = 1'b0;
    srdy = 1'b0;
    sop  = 1'b0;
    eop  = 1'b0;
    dat  = '0;
    case (state_q)
      S_HDR0: begin
        vld = 1'b1;
        sop = 1'b1;
        dat = SYNC_WORD;
      end
      S_HDR1: begin
        vld = 1'b1;
        dat = frame_q;
      end
      S_HDR2: begin
        vld = 1'b1;
        dat = tslat_q;
      end
      // Zero-latency pass-through: backpressure goes straight upstream.
      S_PAY: begin
        vld  = st.sample_valid;
        srdy = st.data_out_ready;
        dat  = st.sample_data;
`ifndef FRAMER_CHECKSUM_EN
        eop  = pay_last;
`endif
      end
`ifdef FRAMER_CHECKSUM_EN
      S_TRL: begin
        vld = 1'b1;
        eop = 1'b1;
        dat = csum_q;
      end
`endif
      default: ;
    endcase
  end

  assign st.data_out_valid         = vld & ~rst_reset;
  assign st.sample_ready           = srdy & ~rst_reset;
  assign st.data_out_startofpacket = sop & ~rst_reset;
  assign st.data_out_endofpacket   = eop & ~rst_reset;
  assign st.data_out_data          = rst_reset ? '0 : dat;
  assign st.data_out_empty         = 2'b00;
  assign frame_count               = frame_q;

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    tslat_d = tslat_q;
    word_d  = word_q;
`ifdef FRAMER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (enable & st.sample_valid) begin
          tslat_d = ts_q;
          state_d = S_HDR0;
        end
      end
      S_HDR0: if (beat) state_d = S_HDR1;
      S_HDR1: if (beat) state_d = S_HDR2;
      S_HDR2: begin
`ifdef FRAMER_CHECKSUM_EN
        csum_d = '0;
`endif
        if (beat) begin
          word_d  = '0;
          state_d = S_PAY;
        end
      end
      S_PAY: begin
        if (beat) begin
          word_d = word_q + 16'd1;
`ifdef FRAMER_CHECKSUM_EN
          csum_d = csum_q ^ st.sample_data;
          if (pay_last) state_d = S_TRL;
`else
          if (pay_last) begin
            frame_d = frame_q + 32'd1;
            state_d = S_IDLE;
          end
`endif
        end
      end
`ifdef FRAMER_CHECKSUM_EN
      S_TRL: begin
        if (beat) begin
          frame_d = frame_q + 32'd1;
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (rst_reset) begin
      state_q <= S_IDLE;
      frame_q <= '0;
      ts_q    <= '0;
      tslat_q <= '0;
      word_q  <= '0;
`ifdef FRAMER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      ts_q    <= ts_q + 32'd1;
      tslat_q <= tslat_d;
      word_q  <= word_d;
`ifdef FRAMER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_packet_framer.sv
// tb_packet_framer: randomized stimulus, packet-level reference model, scoreboard.
// Honours FRAMER_CHECKSUM_EN when the build defines it.
module tb_packet_framer;
  localparam int PW = 4;
  localparam logic [31:0] SYNC = 32'hA5A5_0001;

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic        pay;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] frame_count;
  logic [31:0] cyc;

  beat_t sb[$];
  int checks = 0;
  int failures = 0;
  int done = 0;
  int frames = 0;

  logic [31:0] cur [PW];
  logic [31:0] fnum = 0;
  int started = 0;
  int pay_idx = 0;
  bit in_frame = 0;
  bit rst_done = 0;
  bit acc;

  packet_framer_if bus();

  packet_framer #(
    .PAYLOAD_WORDS(PW),
    .SYNC_WORD(SYNC)
  ) dut (
    .clk_clk(clk),
    .rst_reset(rst),
    .enable(enable),
    .st(bus),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic beat_t mk(input logic [31:0] d, input logic s,
                               input logic e, input logic p, input logic l);
    beat_t b;
    b.data = d; b.sop = s; b.eop = e; b.pay = p; b.last = l;
    return b;
  endfunction

  // Whole expected packet is known the moment a frame is launched.
  task automatic start_frame();
    logic [31:0] cs;
    cs = 0;
    sb.push_back(mk(SYNC, 1'b1, 1'b0, 1'b0, 1'b0));
    sb.push_back(mk(fnum, 1'b0, 1'b0, 1'b0, 1'b0));
    sb.push_back(mk(cyc,  1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < PW; i++) begin
      cur[i] = (started == 0) ? (32'd1 << i) : $urandom;
      cs ^= cur[i];
`ifdef FRAMER_CHECKSUM_EN
      sb.push_back(mk(cur[i], 1'b0, 1'b0, 1'b1, 1'b0));
`else
      sb.push_back(mk(cur[i], 1'b0, i == PW - 1, 1'b1, i == PW - 1));
`endif
    end
`ifdef FRAMER_CHECKSUM_EN
    sb.push_back(mk(cs, 1'b0, 1'b1, 1'b0, 1'b1));
`endif
    fnum++;
    started++;
    in_frame = 1;
    pay_idx = 0;
    enable = 1;
    bus.sample_valid = 1;
    bus.sample_data = cur[0];
  endtask

  initial begin : mon
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk({bus.data_out_valid, bus.sample_ready, bus.data_out_startofpacket,
             bus.data_out_endofpacket, bus.data_out_data} == 0, "reset_outs",
            {bus.data_out_valid, bus.sample_ready, bus.data_out_startofpacket,
             bus.data_out_endofpacket, bus.data_out_data}, 0);
        sb.delete();
        done = 0;
      end else begin
        chk(frame_count == done, "frame_count", frame_count, done);
        chk(bus.data_out_empty == 0, "empty", bus.data_out_empty, 0);
        if (sb.size() == 0)
          chk(!bus.sample_ready && !bus.data_out_valid, "idle_quiet",
              {bus.sample_ready, bus.data_out_valid}, 0);
        else if (bus.data_out_valid) begin
          e = sb[0];
          chk({bus.data_out_startofpacket, bus.data_out_endofpacket, bus.data_out_data}
              == {e.sop, e.eop, e.data}, "beat",
              {bus.data_out_startofpacket, bus.data_out_endofpacket, bus.data_out_data},
              {e.sop, e.eop, e.data});
          chk(bus.sample_ready == (e.pay ? bus.data_out_ready : 1'b0), "sample_ready",
              bus.sample_ready, e.pay ? bus.data_out_ready : 1'b0);
          if (bus.data_out_ready) begin
            void'(sb.pop_front());
            if (e.last) begin
              done++;
              frames++;
            end
          end
        end
      end
    end
  end

  initial begin : drv
    bit stop;
    bus.sample_valid = 0;
    bus.sample_data = 0;
    bus.data_out_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    for (int c = 0; c < 6000; c++) begin
      stop = (c >= 5000);
      @(negedge clk);
      acc = bus.sample_valid & bus.sample_ready;
      @(posedge clk);
      #1;
      if (rst) begin
        rst = 0;
        in_frame = 0;
        fnum = 0;
        acc = 0;
      end
      if (in_frame && acc) begin
        pay_idx++;
        if (pay_idx == PW) in_frame = 0;
      end
      if (stop && !in_frame && sb.size() == 0) break;
      bus.data_out_ready = ($urandom_range(0, 3) != 0);
      if (in_frame && pay_idx == 2 && !rst_done && fnum == 6) begin
        rst = 1;
        rst_done = 1;
      end
      if (!in_frame && sb.size() == 0) begin
        if (!stop && (started == 0 ? (cyc == 10) : ($urandom_range(0, 2) == 0)))
          start_frame();
        else begin
          enable = ($urandom_range(0, 1) == 1);
          bus.sample_valid = !enable && ($urandom_range(0, 1) == 1);
          bus.sample_data = $urandom;
        end
      end else if (in_frame) begin
        enable = ($urandom_range(0, 1) == 1);
        bus.sample_valid = ($urandom_range(0, 3) != 0);
        bus.sample_data = bus.sample_valid ? cur[pay_idx] : $urandom;
      end else begin
        enable = ($urandom_range(0, 1) == 1);
        bus.sample_valid = ($urandom_range(0, 1) == 1);
        bus.sample_data = $urandom;
      end
    end
    enable = 0;
    bus.sample_valid = 0;
    repeat (2) @(negedge clk);
    chk(sb.size() == 0 && !in_frame, "drain", sb.size(), 0);
    chk(frames >= 50, "frames_done", frames, 50);
    chk(rst_done, "reset_hit", rst_done, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
